multicycle_control_fsm: RTL and testbench

- Multi-cycle successor to the single-cycle opcode decoder. It sequences each RISC-V instruction through FETCH, DECODE, EXEC, MEM and WB states.
- Drives all datapath enables for a shared-memory multi-cycle core, and waits on a memory ready handshake with a parametrised timeout.
- Traps on illegal opcodes or memory timeout, and counts retired instructions.
- Sits between the instruction register and the datapath muxes, register file and unified memory port.

---
 rtl/riscv_ctrl_pkg.sv | 56 +++++
 rtl/mem_wait_timer.sv | 31 +++
 rtl/multicycle_control_fsm.sv | 214 +++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared RISC-V control definitions: opcodes, FSM states, ALU operand/op codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_ctrl_pkg;

   // Base-ISA major opcodes (IR[6:0]) supported by the multi-cycle core
   localparam logic [6:0] R_TYPE = 7'b0110011;
   localparam logic [6:0] I_TYPE = 7'b0010011;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] BRANCH = 7'b1100011;

   // Controller states; values are visible on the debug state port
   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      TRAP   = 3'd5
   } state_t;

   // alu_op codes
   localparam logic [1:0] ALU_OP_ADD    = 2'b00;
   localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
   localparam logic [1:0] ALU_OP_RTYPE  = 2'b10;
   localparam logic [1:0] ALU_OP_ITYPE  = 2'b11;

   // alu_src_b codes (2'b11 is reserved)
   localparam logic [1:0] SRC_B_RS2  = 2'b00;
   localparam logic [1:0] SRC_B_FOUR = 2'b01;
   localparam logic [1:0] SRC_B_IMM  = 2'b10;

   // Datapath control bundle driven by the controller each cycle
   typedef struct packed {
      logic       pc_write;
      logic       pc_src;
      logic       ir_write;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       reg_write;
      logic       mem_to_reg;
      logic       retire;
   } ctrl_t;

   // True for opcodes the core implements; anything else traps
   function automatic logic is_legal_opcode(input logic [6:0] op);
      return (op == R_TYPE) || (op == I_TYPE) || (op == LOAD) ||
             (op == STORE)  || (op == BRANCH);
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts memory wait cycles and flags when the wait reaches MEM_TIMEOUT.
// Latency: expired reflects the registered count (no input-to-output path).
// Backpressure: none; clear wins over count-enable, count saturates at all-ones.
module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 15,
   parameter int TO_W        = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic cnt_en,
   output logic expired
);

   localparam logic [TO_W-1:0] LIMIT = TO_W'(MEM_TIMEOUT);

   logic [TO_W-1:0] cnt_q;

   // Wait counter: cleared on reset or state entry, saturating increment otherwise
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         cnt_q <= '0;
      end else if (cnt_en && (cnt_q != {TO_W{1'b1}})) begin
         cnt_q <= cnt_q + TO_W'(1);
      end
   end

   // A zero limit disables the timeout entirely (wait forever)
   assign expired = (MEM_TIMEOUT != 0) && (cnt_q == LIMIT);

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RISC-V controller: FETCH/DECODE/EXEC/MEM/WB sequencing, traps, retire count.
// Latency: R/I 4, BRANCH 3, STORE 4, LOAD 5 cycles plus one per memory wait cycle.
// Backpressure: stalls in FETCH/MEM until mem_ready; traps after MEM_TIMEOUT idle cycles.
module multicycle_control_fsm
   import riscv_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15,
   parameter int TO_W        = 4,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [6:0]       opcode,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             pc_src,
   output logic             ir_write,
   output logic             i_or_d,
   output logic             mem_read,
   output logic             mem_write,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic             reg_write,
   output logic             mem_to_reg,
   output logic             retire,
   output logic [CNT_W-1:0] instret,
   output logic [2:0]       state,
   output logic             illegal_instr,
   output logic             timeout_err
);

   state_t           state_q;
   state_t           state_d;
   logic [6:0]       opcode_q;
   logic             illegal_q;
   logic             timeout_q;
   logic [CNT_W-1:0] instret_q;
   ctrl_t            ctrl;
   ctrl_t            ctrl_out;
   logic             set_illegal;
   logic             set_timeout;
   logic             tmr_clear;
   logic             tmr_cnt_en;
   logic             tmr_expired;

   // Next-state and control decode from current state, latched opcode and handshakes
   always_comb begin
      ctrl        = '0;
      state_d     = state_q;
      set_illegal = 1'b0;
      set_timeout = 1'b0;
      case (state_q)
         FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = SRC_B_FOUR;
            ctrl.alu_op    = ALU_OP_ADD;
            if (mem_ready) begin
               ctrl.ir_write = 1'b1;
               ctrl.pc_write = 1'b1;
               state_d       = DECODE;
            end else if (tmr_expired) begin
               set_timeout = 1'b1;
               state_d     = TRAP;
            end
         end
         DECODE: begin
            if (is_legal_opcode(opcode)) begin
               state_d = EXEC;
            end else begin
               set_illegal = 1'b1;
               state_d     = TRAP;
            end
         end
         EXEC: begin
            ctrl.alu_src_a = 1'b1;
            case (opcode_q)
               R_TYPE: begin
                  ctrl.alu_src_b = SRC_B_RS2;
                  ctrl.alu_op    = ALU_OP_RTYPE;
                  state_d        = WB;
               end
               I_TYPE: begin
                  ctrl.alu_src_b = SRC_B_IMM;
                  ctrl.alu_op    = ALU_OP_ITYPE;
                  state_d        = WB;
               end
               LOAD, STORE: begin
                  ctrl.alu_src_b = SRC_B_IMM;
                  ctrl.alu_op    = ALU_OP_ADD;
                  state_d        = MEM;
               end
               BRANCH: begin
                  ctrl.alu_src_b = SRC_B_RS2;
                  ctrl.alu_op    = ALU_OP_BRANCH;
                  ctrl.pc_src    = 1'b1;
                  ctrl.pc_write  = zero;
                  ctrl.retire    = 1'b1;
                  state_d        = FETCH;
               end
               default: begin
                  // Unreachable: DECODE only admits legal opcodes
                  ctrl.alu_src_a = 1'b0;
                  state_d        = FETCH;
               end
            endcase
         end
         MEM: begin
            ctrl.i_or_d = 1'b1;
            if (opcode_q == LOAD) begin
               ctrl.mem_read = 1'b1;
            end else begin
               ctrl.mem_write = 1'b1;
            end
            if (mem_ready) begin
               if (opcode_q == LOAD) begin
                  state_d = WB;
               end else begin
                  ctrl.retire = 1'b1;
                  state_d     = FETCH;
               end
            end else if (tmr_expired) begin
               set_timeout = 1'b1;
               state_d     = TRAP;
            end
         end
         WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.retire     = 1'b1;
            ctrl.mem_to_reg = (opcode_q == LOAD);
            state_d         = FETCH;
         end
         TRAP: begin
            state_d = TRAP;
         end
         default: begin
            state_d = FETCH;
         end
      endcase
   end

   // Restart the wait count on each entry to a memory-wait state
   assign tmr_clear  = (state_d != state_q) && ((state_d == FETCH) || (state_d == MEM));
   assign tmr_cnt_en = ((state_q == FETCH) || (state_q == MEM)) && !mem_ready;

   mem_wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT),
      .TO_W        (TO_W)
   ) u_mem_wait_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (tmr_clear),
      .cnt_en  (tmr_cnt_en),
      .expired (tmr_expired)
   );

   // State register and opcode latch; opcode is captured while in DECODE
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= FETCH;
         opcode_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == DECODE) begin
            opcode_q <= opcode;
         end
      end
   end

   // Sticky error flags, cleared only by reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         illegal_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         if (set_illegal) illegal_q <= 1'b1;
         if (set_timeout) timeout_q <= 1'b1;
      end
   end

   // Retired-instruction counter, wraps naturally at CNT_W bits
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         instret_q <= '0;
      end else if (ctrl.retire) begin
         instret_q <= instret_q + CNT_W'(1);
      end
   end

   // Hold every datapath enable low while reset is asserted
   always_comb begin
      ctrl_out = ctrl;
      if (!rst_n) ctrl_out = '0;
   end

   assign pc_write      = ctrl_out.pc_write;
   assign pc_src        = ctrl_out.pc_src;
   assign ir_write      = ctrl_out.ir_write;
   assign i_or_d        = ctrl_out.i_or_d;
   assign mem_read      = ctrl_out.mem_read;
   assign mem_write     = ctrl_out.mem_write;
   assign alu_src_a     = ctrl_out.alu_src_a;
   assign alu_src_b     = ctrl_out.alu_src_b;
   assign alu_op        = ctrl_out.alu_op;
   assign reg_write     = ctrl_out.reg_write;
   assign mem_to_reg    = ctrl_out.mem_to_reg;
   assign retire        = ctrl_out.retire;
   assign instret       = instret_q;
   assign state         = state_q;
   assign illegal_instr = illegal_q;
   assign timeout_err   = timeout_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: per-cycle expected-output vectors from an instruction-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_multicycle_control_fsm;

   localparam int MEM_TO = 15;

   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_LD = 7'b0000011;
   localparam logic [6:0] OP_ST = 7'b0100011;
   localparam logic [6:0] OP_BR = 7'b1100011;

   localparam logic [2:0] S_FETCH = 3'd0;
   localparam logic [2:0] S_DEC   = 3'd1;
   localparam logic [2:0] S_EXEC  = 3'd2;
   localparam logic [2:0] S_MEM   = 3'd3;
   localparam logic [2:0] S_WB    = 3'd4;
   localparam logic [2:0] S_TRAP  = 3'd5;

   typedef struct packed {
      logic       pc_write;
      logic       pc_src;
      logic       ir_write;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       reg_write;
      logic       mem_to_reg;
      logic       retire;
      logic [3:0] instret;
      logic [2:0] state;
      logic       illegal;
      logic       timeout;
   } obs_t;

   typedef struct {
      logic       rst_n;
      logic [6:0] opcode;
      logic       zero;
      logic       mem_ready;
      obs_t       exp;
      int         tag;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] opcode;
   logic       zero;
   logic       mem_ready;
   logic       pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write, alu_src_a;
   logic [1:0] alu_src_b, alu_op;
   logic       reg_write, mem_to_reg, retire;
   logic [3:0] instret;
   logic [2:0] state;
   logic       illegal_instr, timeout_err;

   multicycle_control_fsm #(
      .MEM_TIMEOUT (MEM_TO),
      .TO_W        (4),
      .CNT_W       (4)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .opcode        (opcode),
      .zero          (zero),
      .mem_ready     (mem_ready),
      .pc_write      (pc_write),
      .pc_src        (pc_src),
      .ir_write      (ir_write),
      .i_or_d        (i_or_d),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .alu_op        (alu_op),
      .reg_write     (reg_write),
      .mem_to_reg    (mem_to_reg),
      .retire        (retire),
      .instret       (instret),
      .state         (state),
      .illegal_instr (illegal_instr),
      .timeout_err   (timeout_err)
   );

   always #5 clk = ~clk;

   vec_t       vq[$];
   logic [2:0] m_state;
   logic [3:0] m_instret;
   logic       m_ill;
   logic       m_to;
   int         cur_tag;
   int         n_vec;
   int         n_err;

   function automatic logic [6:0] r7();
      return 7'($urandom);
   endfunction

   function automatic logic r1();
      return 1'($urandom);
   endfunction

   function automatic logic legal(input logic [6:0] op);
      logic [6:0] ops [5];
      ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR};
      foreach (ops[k]) if (ops[k] == op) return 1'b1;
      return 1'b0;
   endfunction

   task automatic check_cond(input logic ok, input int idx, input int tag, input string what);
      if (ok !== 1'b1) begin
         n_err++;
         $display("FAIL vec %0d seq %0d: %s (state %0d instret %0d ill %b to %b)",
                  idx, tag, what, state, instret, illegal_instr, timeout_err);
      end
   endtask

   // One clock cycle of the expected trace; registered fields come from the model's
   // architectural state, which is then advanced to what the next cycle should show.
   task automatic cyc(input logic rst, input logic [6:0] op, input logic z, input logic rdy,
                      input obs_t c, input logic [2:0] nxt, input logic set_ill, input logic set_to);
      vec_t v;
      if (!rst) c = '0;
      c.state   = m_state;
      c.instret = m_instret;
      c.illegal = m_ill;
      c.timeout = m_to;
      v.rst_n = rst; v.opcode = op; v.zero = z; v.mem_ready = rdy; v.exp = c; v.tag = cur_tag;
      vq.push_back(v);
      if (!rst) begin
         m_state = S_FETCH; m_instret = '0; m_ill = 1'b0; m_to = 1'b0;
      end else begin
         if (c.retire) m_instret = m_instret + 4'd1;
         m_state = nxt;
         m_ill   = m_ill | set_ill;
         m_to    = m_to | set_to;
      end
   endtask

   task automatic do_reset(input int n);
      for (int k = 0; k < n; k++) cyc(1'b0, r7(), r1(), r1(), '0, S_FETCH, 1'b0, 1'b0);
   endtask

   task automatic trap_cycles(input int n);
      for (int k = 0; k < n; k++) cyc(1'b1, r7(), r1(), r1(), '0, S_TRAP, 1'b0, 1'b0);
   endtask

   // Expand one instruction into its cycle-by-cycle expected trace.
   // wf/wm: memory wait cycles before ready in fetch/data access; abort_mem>=0 resets
   // on that data-access cycle (with mem_ready high) instead of completing.
   task automatic run_instr(input logic [6:0] op, input logic z, input int wf, input int wm,
                            input int abort_mem);
      obs_t c;
      logic rdy;
      logic is_ld;
      for (int i = 0; i <= MEM_TO + 1; i++) begin
         rdy = (i == wf);
         c = '0; c.mem_read = 1'b1; c.alu_src_b = 2'b01;
         c.ir_write = rdy; c.pc_write = rdy;
         if (rdy) begin
            cyc(1'b1, r7(), r1(), 1'b1, c, S_DEC, 1'b0, 1'b0);
            break;
         end
         if (i == MEM_TO) begin
            cyc(1'b1, r7(), r1(), 1'b0, c, S_TRAP, 1'b0, 1'b1);
            return;
         end
         cyc(1'b1, r7(), r1(), 1'b0, c, S_FETCH, 1'b0, 1'b0);
      end
      if (!legal(op)) begin
         cyc(1'b1, op, r1(), r1(), '0, S_TRAP, 1'b1, 1'b0);
         return;
      end
      cyc(1'b1, op, r1(), r1(), '0, S_EXEC, 1'b0, 1'b0);
      c = '0; c.alu_src_a = 1'b1;
      if (op == OP_BR) begin
         c.alu_op = 2'b01; c.pc_src = 1'b1; c.pc_write = z; c.retire = 1'b1;
         cyc(1'b1, r7(), z, r1(), c, S_FETCH, 1'b0, 1'b0);
         return;
      end
      if (op == OP_R || op == OP_I) begin
         c.alu_op    = (op == OP_R) ? 2'b10 : 2'b11;
         c.alu_src_b = (op == OP_R) ? 2'b00 : 2'b10;
         cyc(1'b1, r7(), r1(), r1(), c, S_WB, 1'b0, 1'b0);
      end else begin
         c.alu_src_b = 2'b10;
         cyc(1'b1, r7(), r1(), r1(), c, S_MEM, 1'b0, 1'b0);
         is_ld = (op == OP_LD);
         for (int j = 0; j <= MEM_TO + 1; j++) begin
            if (j == abort_mem) begin
               cyc(1'b0, r7(), r1(), 1'b1, '0, S_FETCH, 1'b0, 1'b0);
               return;
            end
            rdy = (j == wm);
            c = '0; c.i_or_d = 1'b1; c.mem_read = is_ld; c.mem_write = !is_ld;
            if (rdy && is_ld) begin
               cyc(1'b1, r7(), r1(), 1'b1, c, S_WB, 1'b0, 1'b0);
               break;
            end
            if (rdy) begin
               c.retire = 1'b1;
               cyc(1'b1, r7(), r1(), 1'b1, c, S_FETCH, 1'b0, 1'b0);
               return;
            end
            if (j == MEM_TO) begin
               cyc(1'b1, r7(), r1(), 1'b0, c, S_TRAP, 1'b0, 1'b1);
               return;
            end
            cyc(1'b1, r7(), r1(), 1'b0, c, S_MEM, 1'b0, 1'b0);
         end
      end
      c = '0; c.reg_write = 1'b1; c.retire = 1'b1; c.mem_to_reg = (op == OP_LD);
      cyc(1'b1, r7(), r1(), r1(), c, S_FETCH, 1'b0, 1'b0);
   endtask

   task automatic recover_if_trapped();
      if (m_state == S_TRAP) begin
         trap_cycles(int'($urandom_range(1, 4)));
         do_reset(1);
      end
   endtask

   initial begin
      obs_t       act;
      logic [6:0] op;
      int         r;
      int         wf;
      int         wm;
      logic [6:0] ops [5];
      ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR};
      n_vec = 0; n_err = 0;
      rst_n = 1'b0; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
      m_state = S_FETCH; m_instret = '0; m_ill = 1'b0; m_to = 1'b0;

      // Directed multi-cycle sequences
      cur_tag = 1;  do_reset(2);
      cur_tag = 2;  run_instr(OP_R, 1'b0, 0, 0, -1);
      cur_tag = 3;  run_instr(OP_LD, 1'b0, 0, 3, -1);
      cur_tag = 4;  run_instr(OP_BR, 1'b1, 0, 0, -1);
      cur_tag = 5;  run_instr(OP_BR, 1'b0, 0, 0, -1);
      cur_tag = 6;  run_instr(OP_I, 1'b0, 2, 0, -1);
      cur_tag = 7;  run_instr(OP_ST, 1'b0, 1, 2, -1);
      cur_tag = 8;  run_instr(7'b1111111, 1'b0, 0, 0, -1); trap_cycles(20); do_reset(1);
      cur_tag = 9;  run_instr(OP_R, 1'b0, 20, 0, -1); trap_cycles(3); do_reset(1);
      cur_tag = 10; run_instr(OP_R, 1'b0, 15, 0, -1);
      cur_tag = 11; run_instr(OP_LD, 1'b0, 0, 15, -1);
      cur_tag = 12; run_instr(OP_ST, 1'b0, 0, 16, -1); trap_cycles(2); do_reset(1);
      cur_tag = 13; for (int k = 0; k < 17; k++) run_instr(OP_R, 1'b0, 0, 0, -1);
      cur_tag = 14; run_instr(OP_ST, 1'b0, 0, 5, 2);
      cur_tag = 15; run_instr(OP_BR, 1'b1, 0, 0, -1);

      // Randomized instruction mix
      cur_tag = 100;
      for (int n = 0; n < 250; n++) begin
         r  = int'($urandom_range(0, 11));
         op = (r < 5) ? ops[r] : ((r < 11) ? ops[r - 5] : r7());
         wf = ($urandom_range(0, 9) == 0) ? int'($urandom_range(13, 17)) : int'($urandom_range(0, 2));
         wm = ($urandom_range(0, 9) == 0) ? int'($urandom_range(13, 17)) : int'($urandom_range(0, 2));
         run_instr(op, r1(), wf, wm, -1);
         recover_if_trapped();
      end

      @(posedge clk);
      @(posedge clk);
      for (int i = 0; i < vq.size(); i++) begin
         @(negedge clk);
         rst_n     = vq[i].rst_n;
         opcode    = vq[i].opcode;
         zero      = vq[i].zero;
         mem_ready = vq[i].mem_ready;
         #1;
         act = {pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write, alu_src_a,
                alu_src_b, alu_op, reg_write, mem_to_reg, retire, instret, state,
                illegal_instr, timeout_err};
         n_vec++;
         if (act !== vq[i].exp) begin
            n_err++;
            $display("FAIL vec %0d seq %0d: outputs got %h expected %h (state got %0d exp %0d, instret got %0d exp %0d)",
                     i, vq[i].tag, act, vq[i].exp, state, vq[i].exp.state, instret, vq[i].exp.instret);
         end
         if (!vq[i].rst_n) begin
            check_cond({pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write, alu_src_a,
                        alu_src_b, alu_op, reg_write, mem_to_reg, retire} == '0,
                       i, vq[i].tag, "control outputs not forced low during reset");
         end
         if (i > 0 && !vq[i-1].rst_n) begin
            check_cond((state == S_FETCH) && (instret == 4'd0) &&
                       (illegal_instr == 1'b0) && (timeout_err == 1'b0),
                       i, vq[i].tag, "reset state not FETCH with cleared counter and flags");
         end
         if (i > 0 && vq[i].exp.timeout && !vq[i-1].exp.timeout) begin
            check_cond((timeout_err == 1'b1) && (state == S_TRAP),
                       i, vq[i].tag, "expired wait did not trap with timeout_err");
         end
      end
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
